// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg -- shared configuration for the register hazard scoreboard.
//
// Holds the register-file geometry (REG_COUNT, REG_ADDR_W) and the width of
// the per-register pending counter (CNT_W), plus the types built from them.
// Imported by the interface, the counter entry and the top.
package hazard_scoreboard_pkg;

  localparam int REG_COUNT  = 16;
  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [REG_COUNT-1:0]  reg_mask_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if -- ID-stage <-> scoreboard signal bundle.
//
// Handshake: id_valid says a decoded instruction sits in ID. The scoreboard
// answers with hazard (stall request) and issue. The instruction leaves ID on
// exactly those rising edges where issue=1; issue already folds in hazard,
// flush and freeze, so issue plays the role of "ready & valid". While issue=0
// the ID stage must keep presenting the same instruction (or drop it on flush).
//
// Signals:
//   id_valid, src1, src2, two_src       - instruction in ID and its sources
//   id_wb_en, id_dest, id_mem_r_en      - writeback info (load flag)
//   flush, freeze                       - pipeline control
//   hazard, pending, issue              - scoreboard responses
// Modports: master = ID stage, slave = scoreboard.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic      id_valid;
  reg_addr_t src1;
  reg_addr_t src2;
  logic      two_src;
  logic      id_wb_en;
  reg_addr_t id_dest;
  logic      id_mem_r_en;
  logic      flush;
  logic      freeze;
  logic      hazard;
  reg_mask_t pending;
  logic      issue;

  modport master (
    output id_valid, src1, src2, two_src, id_wb_en, id_dest, id_mem_r_en,
    output flush, freeze,
    input  hazard, pending, issue
  );

  modport slave (
    input  id_valid, src1, src2, two_src, id_wb_en, id_dest, id_mem_r_en,
    input  flush, freeze,
    output hazard, pending, issue
  );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// scoreboard_entry -- one register's pending down-counter.
//
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   set       - load set_val this edge (wins over the decrement)
//   set_val   - latency to load
//   freeze    - hold the counter this edge
//   busy      - counter is nonzero (register result not yet usable)
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  cnt_t set_val,
  input  logic freeze,
  output logic busy
);

  cnt_t cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (set) begin
        cnt <= set_val;
      end else if (cnt != '0) begin
        cnt <= cnt - cnt_t'(1);
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- per-register RAW hazard tracker for the ID stage.
//
// Every register r0..r15 owns a 2-bit down-counter; a register is pending
// while its counter is nonzero. An issuing instruction that writes back loads
// its destination counter with the issue latency; the ID instruction stalls
// (hazard) while any register it reads is pending. A dependency resolves in
// the same cycle its counter reaches zero, so no extra bubble is added.
//
// Parameters:
//   WB_LAT   (1..3) - pending cycles for every writer without forwarding
//   LOAD_LAT (1..3) - load-use latency when forwarding is compiled in
// Config macro:
//   FORWARDING_EN - defined: loads set LOAD_LAT-1, other writers set 0
//                   undefined (default): every writer sets WB_LAT
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset, clears all counters
//   id   - hazard_scoreboard_if.slave (ID instruction in; hazard/pending/issue out)
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int WB_LAT   = 2,
  parameter int LOAD_LAT = 2
) (
  input logic                 clk,
  input logic                 rst,
  hazard_scoreboard_if.slave  id
);

  if (WB_LAT < 1 || WB_LAT > 3) begin : g_bad_wb_lat
    $error("hazard_scoreboard: WB_LAT must be 1..3");
  end
  if (LOAD_LAT < 1 || LOAD_LAT > 3) begin : g_bad_load_lat
    $error("hazard_scoreboard: LOAD_LAT must be 1..3");
  end

`ifdef FORWARDING_EN
  // Forwarded ALU results are usable next cycle; only load-use stalls.
  localparam cnt_t LOAD_SET = cnt_t'(LOAD_LAT - 1);
  localparam cnt_t ALU_SET  = '0;
`else
  // Without bypass every consumer waits for writeback.
  localparam cnt_t LOAD_SET = cnt_t'(WB_LAT);
  localparam cnt_t ALU_SET  = cnt_t'(WB_LAT);
`endif

  reg_mask_t busy;
  reg_mask_t set_mask;
  cnt_t      set_val;
  logic      hazard_c;
  logic      issue_c;

  // Uses only pre-edge counters, so src == dest of the same instruction is
  // harmless: its own write cannot stall it.
  assign hazard_c = id.id_valid & (busy[id.src1] | (id.two_src & busy[id.src2]));
  assign issue_c  = id.id_valid & ~hazard_c & ~id.flush & ~id.freeze;

  assign set_val = id.id_mem_r_en ? LOAD_SET : ALU_SET;

  // One-hot destination select; a squashed or stalled instruction marks nothing.
  always_comb begin
    set_mask = '0;
    if (issue_c && id.id_wb_en) begin
      set_mask[id.id_dest] = 1'b1;
    end
  end

  for (genvar r = 0; r < REG_COUNT; r++) begin : g_entry
    scoreboard_entry u_entry (
      .clk     (clk),
      .rst     (rst),
      .set     (set_mask[r]),
      .set_val (set_val),
      .freeze  (id.freeze),
      .busy    (busy[r])
    );
  end

  assign id.hazard  = hazard_c;
  assign id.issue   = issue_c;
  assign id.pending = busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard -- self-checking bench for hazard_scoreboard.
//
// The reference model counts unfrozen clock edges ("active edges") and keeps,
// per register, the active-edge number at which its result becomes usable.
// A register is pending while that release point lies in the future.
// Honours FORWARDING_EN the same way as the design build.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int WB_LAT   = 2;
  localparam int LOAD_LAT = 2;
  localparam int N_RANDOM = 400;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if sb_if ();

  hazard_scoreboard #(
    .WB_LAT   (WB_LAT),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .id  (sb_if)
  );

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int unsigned act_edges = 0;
  int unsigned release_at [REG_COUNT];
  logic [REG_COUNT-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned latency(input logic is_load);
`ifdef FORWARDING_EN
    return is_load ? LOAD_LAT - 1 : 0;
`else
    return WB_LAT;
`endif
  endfunction

  function automatic logic [REG_COUNT-1:0] model_pending();
    logic [REG_COUNT-1:0] p;
    for (int r = 0; r < REG_COUNT; r++) p[r] = (release_at[r] > act_edges);
    return p;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < REG_COUNT; r++) release_at[r] = act_edges;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input int s1, input int s2, input logic two,
                       input logic wb, input int dest, input logic ld,
                       input logic fl, input logic fz);
    sb_if.id_valid    = v;
    sb_if.src1        = 4'(s1);
    sb_if.src2        = 4'(s2);
    sb_if.two_src     = two;
    sb_if.id_wb_en    = wb;
    sb_if.id_dest     = 4'(dest);
    sb_if.id_mem_r_en = ld;
    sb_if.flush       = fl;
    sb_if.freeze      = fz;
  endtask

  task automatic drive_idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  // Checks the pre-edge outputs, clocks once, advances the model.
  task automatic step(input string tag, output logic hz, output logic iss);
    logic [REG_COUNT-1:0] p;
    logic eh;
    logic ei;
    #2;
    p  = model_pending();
    eh = sb_if.id_valid & (p[sb_if.src1] | (sb_if.two_src & p[sb_if.src2]));
    ei = sb_if.id_valid & ~eh & ~sb_if.flush & ~sb_if.freeze;
    exp_q.push_back(p);
    check({tag, ".pending"}, 32'(sb_if.pending), 32'(exp_q.pop_front()));
    check({tag, ".hazard"}, 32'(sb_if.hazard), 32'(eh));
    check({tag, ".issue"}, 32'(sb_if.issue), 32'(ei));
    hz  = sb_if.hazard;
    iss = sb_if.issue;
    @(posedge clk);
    if (!sb_if.freeze) act_edges++;
    if (ei && sb_if.id_wb_en) release_at[sb_if.id_dest] = act_edges + latency(sb_if.id_mem_r_en);
    #1;
  endtask

  task automatic tick(input string tag);
    logic a;
    logic b;
    step(tag, a, b);
  endtask

  // Asynchronous reset pulse away from the clock edge.
  task automatic apply_reset(input string tag);
    logic exp_iss;
    #1 rst = 1'b0;
    #1;
    model_clear();
    exp_iss = sb_if.id_valid & ~sb_if.flush & ~sb_if.freeze;
    check({tag, ".rst_pending"}, 32'(sb_if.pending), 32'h0);
    check({tag, ".rst_hazard"}, 32'(sb_if.hazard), 32'h0);
    check({tag, ".rst_issue"}, 32'(sb_if.issue), 32'(exp_iss));
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    act_edges++;
    #1;
  endtask

  initial begin
    logic hz;
    logic iss;
    logic ld_fz;
    int unsigned lat_fz;

    for (int r = 0; r < REG_COUNT; r++) release_at[r] = 0;
`ifdef FORWARDING_EN
    ld_fz = 1'b1;
`else
    ld_fz = 1'b0;
`endif
    lat_fz = latency(ld_fz);

    // reset state: outputs follow inputs while rst is low
    drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset.pending", 32'(sb_if.pending), 32'h0);
    check("reset.hazard", 32'(sb_if.hazard), 32'h0);
    check("reset.issue", 32'(sb_if.issue), 32'h1);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    act_edges++;
    #1;

`ifndef FORWARDING_EN
    // ADD r3, then SUB reading r3: stalls t1,t2, issues t3
    drive(1'b1, 0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    step("raw.add", hz, iss);
    check("raw.add_issue", 32'(iss), 32'h1);
    drive(1'b1, 3, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    step("raw.t1", hz, iss);
    check("raw.t1_hazard", 32'(hz), 32'h1);
    step("raw.t2", hz, iss);
    check("raw.t2_hazard", 32'(hz), 32'h1);
    step("raw.t3", hz, iss);
    check("raw.t3_issue", 32'(iss), 32'h1);
`else
    // LDR r5 then ADD reading r5 via src2: one stall
    drive(1'b1, 0, 0, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    step("lu.ldr", hz, iss);
    check("lu.ldr_issue", 32'(iss), 32'h1);
    drive(1'b1, 1, 5, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0);
    step("lu.t1", hz, iss);
    check("lu.t1_hazard", 32'(hz), 32'h1);
    step("lu.t2", hz, iss);
    check("lu.t2_issue", 32'(iss), 32'h1);
    // ADD r5 then dependent: no stall
    drive(1'b1, 0, 0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    step("fw.add", hz, iss);
    drive(1'b1, 5, 0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
    step("fw.dep", hz, iss);
    check("fw.dep_hazard", 32'(hz), 32'h0);
    check("fw.dep_issue", 32'(iss), 32'h1);
`endif
    drive_idle();
    for (int k = 0; k < 4; k++) tick("drain");

    // freeze holds r7 pending, release lat_fz unfrozen edges after
    drive(1'b1, 0, 0, 1'b0, 1'b1, 7, ld_fz, 1'b0, 1'b0);
    step("frz.issue", hz, iss);
    check("frz.issue_ok", 32'(iss), 32'h1);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick("frz.hold");
      check("frz.hold_p7", 32'(sb_if.pending[7]), 32'h1);
    end
    drive_idle();
    for (int k = 1; k <= 3; k++) begin
      tick("frz.run");
      check("frz.run_p7", 32'(sb_if.pending[7]), 32'(k < lat_fz));
    end

    // flushed writer never marks its destination
    drive(1'b1, 0, 0, 1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b0);
    step("flush", hz, iss);
    check("flush.issue", 32'(iss), 32'h0);
    check("flush.p9", 32'(sb_if.pending[9]), 32'h0);

    // back-to-back writes to r2 while its counter is 1 reload it
    drive(1'b1, 0, 0, 1'b0, 1'b1, 2, ld_fz, 1'b0, 1'b0);
    tick("b2b.first");
    drive_idle();
    for (int k = 1; k < int'(lat_fz); k++) tick("b2b.wait");
    drive(1'b1, 0, 0, 1'b0, 1'b1, 2, ld_fz, 1'b0, 1'b0);
    step("b2b.second", hz, iss);
    check("b2b.second_issue", 32'(iss), 32'h1);
    drive_idle();
    for (int k = 1; k <= int'(lat_fz); k++) begin
      tick("b2b.run");
      check("b2b.run_p2", 32'(sb_if.pending[2]), 32'(k < int'(lat_fz)));
    end

    // reset mid-stall discards the stall
    drive(1'b1, 0, 0, 1'b0, 1'b1, 3, ld_fz, 1'b0, 1'b0);
    tick("rst.writer");
    drive(1'b1, 3, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    #2;
    check("rst.stalled", 32'(sb_if.hazard), 32'h1);
    apply_reset("rst");
    drive(1'b1, 3, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    step("rst.after", hz, iss);
    check("rst.after_issue", 32'(iss), 32'h1);

    // randomized traffic on a small register window so hazards are frequent
    for (int n = 0; n < N_RANDOM; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        apply_reset("rnd");
      end
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 3),
            $urandom_range(0, 3),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter WB_LAT, default 2: cycles after issue during which a non-load destination stays pending (range 1..3).
REQ-002 SHALL have parameter LOAD_LAT, default 2: pending cycles for a load destination when forwarding is compiled in (range 1..3).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port id_valid  input  1  a decoded instruction is present in ID.
REQ-006 SHALL have port src1  input  4  Rn of the ID instruction.
REQ-007 SHALL have port src2  input  4  Rm, or Rd for stores, of the ID instruction.
REQ-008 SHALL have port two_src  input  1  src2 is read by the ID instruction.
REQ-009 SHALL have port id_wb_en  input  1  the ID instruction writes back.
REQ-010 SHALL have port id_dest  input  4  writeback register of the ID instruction.
REQ-011 SHALL have port id_mem_r_en  input  1  the ID instruction is a load.
REQ-012 SHALL have port flush  input  1  taken branch; the ID instruction is squashed.
REQ-013 SHALL have port freeze  input  1  memory stall; the whole pipeline holds.
REQ-014 SHALL have port hazard  output  1  stall request to ID; combinational.
REQ-015 SHALL have port pending  output  16  per-register pending bits; registered.
REQ-016 SHALL have port issue  output  1  the ID instruction advances this cycle.

Function
REQ-017 SHALL hold one 2-bit down-counter per register r0..r15; pending[r] = (cnt[r] != 0).
REQ-018 SHALL drive hazard = id_valid & (pending[src1] | (two_src & pending[src2])).
REQ-019 SHALL drive issue = id_valid & ~hazard & ~flush & ~freeze.
REQ-020 SHALL, on a clock edge with freeze=1, hold every counter.
REQ-021 SHALL, on a clock edge with freeze=0, decrement every nonzero counter by 1 and leave zero counters at 0.
REQ-022 SHALL, on a clock edge with issue=1 and id_wb_en=1, load cnt[id_dest] with the issue latency (REQ-026/027); this load overrides the decrement of that register.
REQ-023 SHALL ignore id_dest when issue=0; a flushed or hazarded instruction never marks a register.
REQ-024 SHALL resolve a dependency in the same cycle that cnt reaches 0; the consumer issues on that edge with no extra bubble.
REQ-025 SHALL treat src1 == src2 == id_dest as legal; hazard uses the pre-edge counters only.

Configuration
REQ-026 SHALL, with FORWARDING_EN defined, load LOAD_LAT-1 for loads and 0 for non-loads, so that only load-use dependencies stall; default LOAD_LAT=2 gives one bubble.
REQ-027 SHALL, without FORWARDING_EN, load WB_LAT for every writing instruction, load or not.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear every counter and pending to 0; hazard and issue then follow the inputs combinationally.
REQ-029 SHALL, on reset asserted mid-stall, discard all outstanding entries; no stall survives deassertion.

Structure
REQ-030 SHALL take REG_COUNT=16, REG_ADDR_W=4 and CNT_W=2 from the shared configs include.
REQ-031 SHALL implement each per-register counter as sub-module scoreboard_entry (inputs set, set_val, freeze; output busy), instantiated 16 times.

Verification
REQ-032 SHALL cover the following, without FORWARDING_EN: issue ADD r3 at t0, then SUB with src1=r3 -> hazard=1 at t1 and t2, issue=1 at t3.
REQ-033 SHALL cover the following, with FORWARDING_EN: LDR r5 at t0, then ADD with src2=r5 and two_src=1 -> one stall cycle; ADD r5 at t0 then a dependent instruction -> zero stalls.
REQ-034 SHALL cover the following: ADD r7 issued, then freeze=1 for 4 cycles -> pending[7] stays 1 throughout and clears WB_LAT cycles after freeze drops.
REQ-035 SHALL cover the following: id_valid=1, id_wb_en=1, id_dest=r9, flush=1 -> issue=0 and pending[9] remains 0.
REQ-036 SHALL cover the following: back-to-back writes to r2 while cnt[2]=1 -> counter reloads to WB_LAT; rst pulled low mid-count -> pending=16'h0000 immediately.
